// File: rtl/ts_pkg.sv
// Shared types and helpers for the multi-channel temperature-sensor scan readout.
package ts_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StTurn,
    StWaitRise,
    StMeasure,
    StReport
  } ts_state_e;

  // Channel-number width, never below one bit.
  function automatic int unsigned clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned MaxChW    = 4;
  localparam int unsigned MaxCountW = 64;

  typedef struct packed {
    logic [MaxChW-1:0]    ch;
    logic [MaxCountW-1:0] length;
    logic                 timeout;
  } ts_result_t;

endpackage

// File: rtl/ts_sync_edge.sv
// Per-bit 2-FF synchroniser with rising/falling edge strobes on the synchronised value.
module ts_sync_edge #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  logic [Width-1:0] s1_q, s2_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  always_comb begin
    rise_o = s2_q & ~prev_q;
    fall_o = ~s2_q & prev_q;
  end

endmodule

// File: rtl/ts_scan_readout.sv
// Scans enabled temperature-sensor channels: trigger, turnaround, pulse-width measure, stream out.
// Optional TS_AVG_EN: average 2^AVG_LOG2 samples per channel.
module ts_scan_readout
  import ts_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned TS_COUNT_WIDTH = 32,
  parameter int unsigned TRIG_CYCLES    = 1,
  parameter int unsigned TURN_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned AVG_LOG2       = 2
) (
  input  logic                      clk_100MHz,
  input  logic                      RESET_N,
  input  logic                      start,
  input  logic [N_CH-1:0]           ch_mask,
  output logic [N_CH-1:0]           ts_o,
  output logic [N_CH-1:0]           ts_oe,
  input  logic [N_CH-1:0]           ts_i,
  output logic [clog2(N_CH)-1:0]    res_ch,
  output logic [TS_COUNT_WIDTH-1:0] res_length,
  output logic                      res_timeout,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned ChW = clog2(N_CH);

  function automatic logic [ChW-1:0] lowest_set(input logic [N_CH-1:0] m);
    lowest_set = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = ChW'(i);
    end
  endfunction

  ts_state_e               state_q;
  logic [ChW-1:0]          ch_q;
  logic [N_CH-1:0]         rem_q, rem_d;
  logic [31:0]             timer_q;
  logic [TS_COUNT_WIDTH-1:0] len_q, res_length_q;
  logic [N_CH-1:0]         ts_o_q, ts_oe_q, ch_onehot;
  logic                    res_timeout_q, res_valid_q, busy_q, done_q;
  logic [ChW-1:0]          start_ch, next_ch;
  logic [N_CH-1:0]         ts_rise, ts_fall;

  ts_sync_edge #(
    .Width(N_CH)
  ) u_sync (
    .clk_i (clk_100MHz),
    .rst_ni(RESET_N),
    .d_i   (ts_i),
    .rise_o(ts_rise),
    .fall_o(ts_fall)
  );

`ifdef TS_AVG_EN
  localparam int unsigned AccW = TS_COUNT_WIDTH + AVG_LOG2;
  logic [AccW-1:0]     acc_q, acc_sum;
  logic [AVG_LOG2-1:0] samp_q;
  always_comb acc_sum = acc_q + AccW'(len_q);
`else
  logic unused_avg_log2;
  assign unused_avg_log2 = (AVG_LOG2 != 0);
`endif

  always_comb begin
    ch_onehot = N_CH'(1) << ch_q;
    rem_d     = rem_q & ~ch_onehot;
    start_ch  = lowest_set(ch_mask);
    next_ch   = lowest_set(rem_d);
  end

  always_ff @(posedge clk_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= StIdle;
      ch_q          <= '0;
      rem_q         <= '0;
      timer_q       <= '0;
      len_q         <= '0;
      ts_o_q        <= '0;
      ts_oe_q       <= '0;
      res_length_q  <= '0;
      res_timeout_q <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef TS_AVG_EN
      acc_q         <= '0;
      samp_q        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (|ch_mask) begin
              rem_q   <= ch_mask;
              ch_q    <= start_ch;
              busy_q  <= 1'b1;
              ts_o_q  <= N_CH'(1) << start_ch;
              ts_oe_q <= N_CH'(1) << start_ch;
              timer_q <= '0;
`ifdef TS_AVG_EN
              acc_q   <= '0;
              samp_q  <= '0;
`endif
              state_q <= StTrig;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StTrig: begin
          if (timer_q == TRIG_CYCLES - 1) begin
            ts_o_q  <= '0;
            timer_q <= '0;
            state_q <= StTurn;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        StTurn: begin
          // One clock driving low, then TURN_CYCLES released.
          if (timer_q == 32'd0) ts_oe_q <= '0;
          if (timer_q == TURN_CYCLES) begin
            timer_q <= '0;
            state_q <= StWaitRise;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        StWaitRise: begin
          if (ts_rise[ch_q]) begin
            len_q   <= TS_COUNT_WIDTH'(1);
            state_q <= StMeasure;
          end else if (timer_q == TIMEOUT_CYCLES - 1) begin
            res_length_q  <= '0;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= StReport;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        StMeasure: begin
          if (ts_fall[ch_q]) begin
`ifdef TS_AVG_EN
            if (samp_q == '1) begin
              res_length_q  <= TS_COUNT_WIDTH'(acc_sum >> AVG_LOG2);
              res_timeout_q <= 1'b0;
              res_valid_q   <= 1'b1;
              state_q       <= StReport;
            end else begin
              acc_q   <= acc_sum;
              samp_q  <= samp_q + AVG_LOG2'(1);
              ts_o_q  <= ch_onehot;
              ts_oe_q <= ch_onehot;
              timer_q <= '0;
              state_q <= StTrig;
            end
`else
            res_length_q  <= len_q;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= StReport;
`endif
          end else if (len_q != '1) begin
            len_q <= len_q + TS_COUNT_WIDTH'(1);
          end
        end
        StReport: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            rem_q       <= rem_d;
            if (rem_d == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              ch_q    <= next_ch;
              ts_o_q  <= N_CH'(1) << next_ch;
              ts_oe_q <= N_CH'(1) << next_ch;
              timer_q <= '0;
`ifdef TS_AVG_EN
              acc_q   <= '0;
              samp_q  <= '0;
`endif
              state_q <= StTrig;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ts_o        = ts_o_q;
    ts_oe       = ts_oe_q;
    res_ch      = ch_q;
    res_length  = res_length_q;
    res_timeout = res_timeout_q;
    res_valid   = res_valid_q;
    busy        = busy_q;
    done        = done_q;
  end

endmodule

// File: tb/tb_ts_scan_readout.sv
// Directed bench for ts_scan_readout: sensor-line model per channel plus a narrow-counter instance.
module tb_ts_scan_readout;
  import ts_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ch_mask;
  logic [3:0]  ts_o, ts_oe, ts_line;
  logic [1:0]  res_ch;
  logic [31:0] res_length;
  logic        res_timeout, res_valid, res_ready, busy, done;

  logic        start2;
  logic [1:0]  ch_mask2, ts_o2, ts_oe2, ts_line2;
  logic [1:0]  drv2 = 2'b00;
  logic [0:0]  res_ch2;
  logic [3:0]  res_length2;
  logic        res_timeout2, res_valid2, res_ready2, busy2, done2;

  logic [3:0]  sens_en = 4'b0000;
  int          sens_len [4];
  logic [3:0]  sens_vec;

  int n_tests = 0;
  int n_fail  = 0;
  bit oe02_seen = 0;
  bit oe_multi  = 0;

  always #5 clk = ~clk;

  ts_scan_readout #(
    .N_CH(4), .TS_COUNT_WIDTH(32), .TRIG_CYCLES(1), .TURN_CYCLES(2),
    .TIMEOUT_CYCLES(50), .AVG_LOG2(2)
  ) dut (
    .clk_100MHz(clk), .RESET_N(rst_n), .start(start), .ch_mask(ch_mask),
    .ts_o(ts_o), .ts_oe(ts_oe), .ts_i(ts_line), .res_ch(res_ch),
    .res_length(res_length), .res_timeout(res_timeout), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .done(done)
  );

  ts_scan_readout #(
    .N_CH(2), .TS_COUNT_WIDTH(4), .TRIG_CYCLES(1), .TURN_CYCLES(2),
    .TIMEOUT_CYCLES(50), .AVG_LOG2(2)
  ) dut2 (
    .clk_100MHz(clk), .RESET_N(rst_n), .start(start2), .ch_mask(ch_mask2),
    .ts_o(ts_o2), .ts_oe(ts_oe2), .ts_i(ts_line2), .res_ch(res_ch2),
    .res_length(res_length2), .res_timeout(res_timeout2), .res_valid(res_valid2),
    .res_ready(res_ready2), .busy(busy2), .done(done2)
  );

  // Line seen by the DUT: own drive when enabled, otherwise the sensor.
  assign ts_line  = (ts_oe & ts_o) | (~ts_oe & sens_vec);
  assign ts_line2 = (ts_oe2 & ts_o2) | (~ts_oe2 & drv2);

  for (genvar c = 0; c < 4; c++) begin : g_sens
    logic drv = 1'b0;
    assign sens_vec[c] = drv;
    always begin
      @(negedge ts_oe[c]);
      if (sens_en[c] && rst_n) begin
        repeat (4) @(posedge clk);
        #1 drv = 1'b1;
        repeat (sens_len[c]) @(posedge clk);
        #1 drv = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && !$onehot0(ts_oe)) oe_multi = 1;
    if (ts_oe[0] || ts_oe[2]) oe02_seen = 1;
  end

  function automatic ts_result_t mk(input int ch, input longint len, input bit to);
    ts_result_t r;
    r.ch      = 4'(ch);
    r.length  = 64'(len);
    r.timeout = to;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input ts_result_t e);
    check({tag, ".ch"}, 64'(res_ch), 64'(e.ch));
    check({tag, ".len"}, 64'(res_length), e.length);
    check({tag, ".timeout"}, 64'(res_timeout), 64'(e.timeout));
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int n = 0;
    while (res_valid !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".valid_seen"}, 64'(res_valid), 64'd1);
  endtask

  task automatic pulse_start(input logic [3:0] m);
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  initial begin
    int n;
    bit bad;
    rst_n = 1'b0; start = 1'b0; ch_mask = '0; res_ready = 1'b0;
    start2 = 1'b0; ch_mask2 = '0; res_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.ts_oe", 64'(ts_oe), 64'd0);
    check("rst.valid", 64'(res_valid), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single channel, 16-clock response.
    sens_en = 4'b0001; sens_len[0] = 16;
    pulse_start(4'b0001);
    check("a.busy", 64'(busy), 64'd1);
    wait_valid("a", 200);
    check_res("a", mk(0, 16, 0));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("a.done", 64'(done), 64'd1);
    check("a.busy_off", 64'(busy), 64'd0);
    check("a.valid_off", 64'(res_valid), 64'd0);
    @(negedge clk);
    check("a.done_pulse", 64'(done), 64'd0);

    // Empty mask: done next cycle, busy never set.
    pulse_start(4'b0000);
    check("b.done", 64'(done), 64'd1);
    check("b.busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("b.done_pulse", 64'(done), 64'd0);

    // Mask 1010, ready held high.
    sens_en = 4'b1010; sens_len[1] = 5; sens_len[3] = 300;
    oe02_seen = 0;
    res_ready = 1'b1;
    pulse_start(4'b1010);
    wait_valid("c1", 200);
    check_res("c1", mk(1, 5, 0));
    @(negedge clk);
    wait_valid("c3", 600);
    check_res("c3", mk(3, 300, 0));
    @(negedge clk);
    check("c.done", 64'(done), 64'd1);
    res_ready = 1'b0;
    check("c.oe02", 64'(oe02_seen), 64'd0);

    // Timeout on ch1, ch2 responds.
    sens_en = 4'b0100; sens_len[2] = 3;
    res_ready = 1'b1;
    pulse_start(4'b0110);
    n = 0;
    while (ts_oe[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    while (ts_oe[1] !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("d.latency_ok", 64'(n >= 50 && n <= 54), 64'd1);
    check_res("d1", mk(1, 0, 1));
    @(negedge clk);
    wait_valid("d2", 200);
    check_res("d2", mk(2, 3, 0));
    @(negedge clk);
    check("d.done", 64'(done), 64'd1);
    res_ready = 1'b0;

    // Backpressure with an ignored start during the stall.
    sens_en = 4'b0011; sens_len[0] = 7; sens_len[1] = 9;
    pulse_start(4'b0011);
    wait_valid("e0", 200);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_length !== 32'd7 ||
          res_timeout !== 1'b0 || ts_oe !== 4'b0000) bad = 1;
      start   = (i == 5);
      ch_mask = 4'b1111;
      @(negedge clk);
    end
    start = 1'b0;
    check("e.stall_stable", 64'(bad), 64'd0);
    check_res("e0", mk(0, 7, 0));
    check("e.busy", 64'(busy), 64'd1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    wait_valid("e1", 200);
    check_res("e1", mk(1, 9, 0));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("e.done", 64'(done), 64'd1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy !== 1'b0 || res_valid !== 1'b0) bad = 1;
      @(negedge clk);
    end
    check("e.start_ignored", 64'(bad), 64'd0);

    // Reset during MEASURE, then a clean scan.
    sens_en = 4'b0001; sens_len[0] = 200;
    pulse_start(4'b0001);
    repeat (30) @(negedge clk);
    check("f.busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("f.ts_oe", 64'(ts_oe), 64'd0);
    check("f.ts_o", 64'(ts_o), 64'd0);
    check("f.busy", 64'(busy), 64'd0);
    check("f.valid", 64'(res_valid), 64'd0);
    check("f.len", 64'(res_length), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    sens_len[0] = 16;
    pulse_start(4'b0001);
    wait_valid("f2", 200);
    check_res("f2", mk(0, 16, 0));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("f2.done", 64'(done), 64'd1);

    // 4-bit counter saturates on a 20-clock pulse.
    res_ready2 = 1'b1;
    ch_mask2 = 2'b01; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (ts_oe2[0] !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(posedge clk);
    #1 drv2[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1 drv2[0] = 1'b0;
    n = 0;
    while (res_valid2 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("g.valid_seen", 64'(res_valid2), 64'd1);
    check("g.len_sat", 64'(res_length2), 64'd15);
    check("g.timeout", 64'(res_timeout2), 64'd0);
    check("g.ch", 64'(res_ch2), 64'd0);
    @(negedge clk);
    check("g.done", 64'(done2), 64'd1);

    check("oe_onehot", 64'(oe_multi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_scan_readout.md
Name: ts_scan_readout

Overview:
- Multi-channel successor to the single-channel temperature-sensor pulse readout.
- Scans up to N_CH on-chip temperature sensors in turn, one pass per start request. Channels not enabled in ch_mask are skipped.
- For each channel: drives a trigger pulse on the shared-style bidirectional sensor line, releases the line, then measures the width of the sensor's response pulse in clk_100MHz cycles.
- Results stream out one channel at a time with a ready/valid handshake. Sits between the pixel-config control registers and the result FIFO.

Parameters:
- N_CH, 4, number of sensor channels (1..16)
- TS_COUNT_WIDTH, 32, width of the pulse-length counter and result
- TRIG_CYCLES, 1, trigger pulse width in clocks (>=1)
- TURN_CYCLES, 2, bus-release turnaround before listening (>=1)
- TIMEOUT_CYCLES, 100000, maximum wait for the response rising edge
- AVG_LOG2, 2, log2 of samples per channel; used only with the optional feature

Ports:
- clk_100MHz  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- start  in  1  one-cycle scan request; ignored while busy
- ch_mask  in  N_CH  channel enable; sampled on start
- ts_o  out  N_CH  per-channel line drive value
- ts_oe  out  N_CH  per-channel output enable; the top level builds the tristate
- ts_i  in  N_CH  per-channel line input, asynchronous
- res_ch  out  clog2(N_CH) max 1  channel number of the result
- res_length  out  TS_COUNT_WIDTH  measured high time, in clocks
- res_timeout  out  1  no response rising edge within TIMEOUT_CYCLES
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts the result
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after the last channel is accepted

Behaviour:
- Reset: all outputs 0, ts_oe = 0, FSM in IDLE. Asserting RESET_N low mid-scan aborts immediately; no done pulse.
- ts_i passes through a 2-FF synchroniser per channel. Edge detection uses the synchronised value.
- FSM states and transitions:
  - IDLE: on start with ch_mask != 0, latch the mask, set busy = 1, select the lowest set channel, go to TRIG. On start with ch_mask == 0, pulse done next cycle and never assert busy.
  - TRIG: ts_oe[ch] = 1 and ts_o[ch] = 1 for TRIG_CYCLES clocks.
  - TURN: ts_oe[ch] = 1 and ts_o[ch] = 0 for one clock, then ts_oe[ch] = 0 for TURN_CYCLES clocks.
  - WAIT_RISE: wait for a synchronised rising edge.
    - A line already high on entry is not a rising edge.
    - If the wait counter reaches TIMEOUT_CYCLES, go to REPORT with res_timeout = 1 and res_length = 0.
  - MEASURE: the counter starts at 1 on the rising-edge cycle and increments each clock while the synchronised line stays high. It saturates at all-ones and does not wrap. The falling edge goes to REPORT. A saturated count must still end on the falling edge.
  - REPORT: hold res_valid = 1 with stable res_* until res_ready. The acceptance cycle advances to the next set mask bit (TRIG), or to IDLE with a done pulse.
- Only the selected channel ever has ts_oe = 1. Unselected channels keep ts_o = 0 and ts_oe = 0.
- Response high of H clocks gives res_length = H exactly. Synchroniser latency affects timing only.
- start is ignored while busy = 1. busy falls in the same cycle done pulses.
- res_ready asserted while res_valid = 0 has no effect.

Optional Feature:
- Macro: TS_AVG_EN.
- When defined: each enabled channel runs TRIG..MEASURE 2^AVG_LOG2 times back to back, summing lengths in a TS_COUNT_WIDTH+AVG_LOG2 accumulator. REPORT presents sum >> AVG_LOG2, i.e. truncated.
- Any timeout within a channel's series aborts that series and reports res_timeout = 1, res_length = 0.
- When not defined: one sample per channel; AVG_LOG2 is unused.

Decomposition:
- Package ts_pkg: FSM state enum (IDLE, TRIG, TURN, WAIT_RISE, MEASURE, REPORT), clog2 helper, result struct {ch, length, timeout}.
- One sub-module, ts_sync_edge: parametrised-width 2-FF synchroniser with rising/falling edge outputs. Instantiated once with width N_CH.

Test Plan:
- Single channel: N_CH = 4, ch_mask = 4'b0001, start, sensor model holds line high 16 clocks after turnaround.
  - Expect res_ch = 0, res_length = 16, res_timeout = 0, then done.
- Mask 4'b1010, lengths 5 and 300, res_ready held high.
  - Expect results ch1 = 5 then ch3 = 300.
  - ts_oe never asserted on ch0 or ch2.
- Timeout: TIMEOUT_CYCLES = 50, channel never responds.
  - Expect res_timeout = 1, res_length = 0 after about 50 clocks in WAIT_RISE; the scan continues to the next channel.
- Backpressure: res_ready low for 20 cycles while res_valid = 1.
  - Expect res_* stable and no TRIG on the next channel until accepted.
  - A start pulse issued during the stall is ignored.
- Reset mid-MEASURE: drop RESET_N.
  - Expect all outputs 0 and ts_oe = 0 immediately; a fresh start afterwards gives a correct result.
- TS_AVG_EN with AVG_LOG2 = 2 and lengths 10, 11, 12, 13.
  - Expect res_length = 11.
  - Saturation case: TS_COUNT_WIDTH = 4 with a 20-clock pulse gives res_length = 15.
